// File: rtl/md4_pkg.sv
// Shared types for the md4 candidate scheduler.
package md4_pkg;
  localparam int DIGEST_W = 128;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_RUN  = 2'd1,
    SLOT_CMP  = 2'd2
  } slot_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, one-hot grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/md4_sched.sv
// Dispatches candidates to md4 cores and compares returned digests.
// Optional MD4_SCHED_STATS_EN adds compare / spurious-done counters.
module md4_sched
  import md4_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          cand_valid,
  input  logic [IDX_W-1:0]              cand_idx,
  output logic                          cand_ready,
  output logic [NUM_CORES-1:0]          core_start,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES*DIGEST_W-1:0] core_digest,
  input  logic [DIGEST_W-1:0]           target_digest,
  input  logic                          target_load,
  output logic                          match_valid,
  output logic [IDX_W-1:0]              match_idx,
`ifdef MD4_SCHED_STATS_EN
  output logic [31:0]                   stat_done_cnt,
  output logic [15:0]                   stat_err_cnt,
`endif
  output logic                          idle
);
  localparam int PW = $clog2(NUM_CORES);

  slot_t                state [NUM_CORES];
  logic [IDX_W-1:0]     tag   [NUM_CORES];
  logic [DIGEST_W-1:0]  dig   [NUM_CORES];
  logic [DIGEST_W-1:0]  target;
  logic [PW-1:0]        rr_ptr, cmp_ptr;

  logic [NUM_CORES-1:0] free, run, cmp_req;
  logic [NUM_CORES-1:0] disp_gnt, cmp_gnt, spur;
  logic [PW-1:0]        disp_idx, cmp_idx;
  logic                 take, cmp_any;

  always_comb begin
    free     = '0;
    run      = '0;
    cmp_req  = '0;
    disp_idx = '0;
    cmp_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      free[i]    = state[i] == SLOT_FREE;
      run[i]     = state[i] == SLOT_RUN;
      cmp_req[i] = state[i] == SLOT_CMP;
      if (disp_gnt[i]) disp_idx = PW'(i);
      if (cmp_gnt[i])  cmp_idx  = PW'(i);
    end
  end

  assign cand_ready = enable & (|free);
  assign take       = cand_valid & cand_ready;
  assign cmp_any    = |cmp_req;
  assign spur       = core_done & ~run;
  assign idle       = &free;

  rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_disp_arb (
    .req (free),
    .ptr (rr_ptr),
    .gnt (disp_gnt)
  );

  rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_cmp_arb (
    .req (cmp_req),
    .ptr (cmp_ptr),
    .gnt (cmp_gnt)
  );

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(NUM_CORES - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        state[i] <= SLOT_FREE;
        tag[i]   <= '0;
        dig[i]   <= '0;
      end
      target      <= '0;
      rr_ptr      <= '0;
      cmp_ptr     <= '0;
      core_start  <= '0;
      match_valid <= 1'b0;
      match_idx   <= '0;
    end else begin
      core_start  <= take ? disp_gnt : '0;
      match_valid <= 1'b0;
      if (target_load) target <= target_digest;
      // Grant, done and compare only ever touch slots in distinct states.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (take && disp_gnt[i]) begin
          state[i] <= SLOT_RUN;
          tag[i]   <= cand_idx;
        end else if (run[i] && core_done[i]) begin
          state[i] <= SLOT_CMP;
          dig[i]   <= core_digest[i*DIGEST_W +: DIGEST_W];
        end else if (cmp_gnt[i]) begin
          state[i] <= SLOT_FREE;
        end
      end
      if (take) rr_ptr <= ptr_next(disp_idx);
      if (cmp_any) begin
        cmp_ptr <= ptr_next(cmp_idx);
        if (dig[cmp_idx] == target) begin
          match_valid <= 1'b1;
          match_idx   <= tag[cmp_idx];
        end
      end
    end
  end

`ifdef MD4_SCHED_STATS_EN
  logic [4:0]  spur_n;
  logic [16:0] err_sum;

  always_comb begin
    spur_n = '0;
    for (int i = 0; i < NUM_CORES; i++) spur_n = spur_n + 5'(spur[i]);
    err_sum = {1'b0, stat_err_cnt} + 17'(spur_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_done_cnt <= '0;
      stat_err_cnt  <= '0;
    end else begin
      if (cmp_any && stat_done_cnt != 32'hFFFF_FFFF)
        stat_done_cnt <= stat_done_cnt + 32'd1;
      stat_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`else
  logic unused_spur;
  assign unused_spur = ^spur;
`endif
endmodule

// File: tb/tb_md4_sched.sv
// Directed bench for md4_sched: dispatch, compare, spurious done, reset.
module tb_md4_sched;
  import md4_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           cand_valid;
  logic [31:0]    cand_idx;
  logic           cand_ready;
  logic [3:0]     core_start;
  logic [3:0]     core_done;
  logic [511:0]   core_digest;
  logic [127:0]   target_digest;
  logic           target_load;
  logic           match_valid;
  logic [31:0]    match_idx;
  logic           idle;
`ifdef MD4_SCHED_STATS_EN
  logic [31:0]    stat_done_cnt;
  logic [15:0]    stat_err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] D = 128'h31d6cfe0_d16ae931_b73c59d7_e0c089c0;

  always #5 clk = ~clk;

  md4_sched dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .cand_valid    (cand_valid),
    .cand_idx      (cand_idx),
    .cand_ready    (cand_ready),
    .core_start    (core_start),
    .core_done     (core_done),
    .core_digest   (core_digest),
    .target_digest (target_digest),
    .target_load   (target_load),
    .match_valid   (match_valid),
    .match_idx     (match_idx),
`ifdef MD4_SCHED_STATS_EN
    .stat_done_cnt (stat_done_cnt),
    .stat_err_cnt  (stat_err_cnt),
`endif
    .idle          (idle)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    enable        = 1'b1;
    cand_valid    = 1'b0;
    cand_idx      = '0;
    core_done     = '0;
    core_digest   = '0;
    target_digest = '0;
    target_load   = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic dispatch(input logic [31:0] idx);
    cand_valid = 1'b1;
    cand_idx   = idx;
    step();
    cand_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (core_start !== 4'b0000) begin
      errors++;
      $display("FAIL reset_start: got %b want 0000", core_start);
    end
    checks++;
    if (match_valid !== 1'b0 || match_idx !== 32'd0) begin
      errors++;
      $display("FAIL reset_match: got %b/%0d want 0/0", match_valid, match_idx);
    end
    checks++;
    if (idle !== 1'b1 || cand_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got idle=%b rdy=%b want 1/1", idle, cand_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    do_reset();
    cand_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cand_idx = 32'(k);
      step();
      exp = 4'b0001 << k;
      checks++;
      if (core_start !== exp) begin
        errors++;
        $display("FAIL b2b_start%0d: got %b want %b", k, core_start, exp);
      end
    end
    checks++;
    if (cand_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full_ready: got %b want 0", cand_ready);
    end
    step();
    cand_valid = 1'b0;
    checks++;
    if (core_start !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_no_start: got %b want 0000", core_start);
    end
  endtask

  task automatic test_match();
    do_reset();
    target_digest = D;
    target_load   = 1'b1;
    dispatch(32'd5);
    target_load   = 1'b0;
    dispatch(32'd6);
    dispatch(32'd7);
    core_done                = 4'b0100;
    core_digest[256 +: 128]  = D;
    step();
    core_done = '0;
    checks++;
    if (match_valid !== 1'b0) begin
      errors++;
      $display("FAIL match_early: got %b want 0", match_valid);
    end
    step();
    checks++;
    if (match_valid !== 1'b1 || match_idx !== 32'd7) begin
      errors++;
      $display("FAIL match_pulse: got %b/%0d want 1/7", match_valid, match_idx);
    end
    step();
    checks++;
    if (match_valid !== 1'b0 || match_idx !== 32'd7) begin
      errors++;
      $display("FAIL match_hold: got %b/%0d want 0/7", match_valid, match_idx);
    end
    checks++;
    if (dut.state[2] !== SLOT_FREE) begin
      errors++;
      $display("FAIL match_free: got %0d want FREE", dut.state[2]);
    end
  endtask

  task automatic test_no_match();
    logic [3:0] exp_free [3];
    logic [3:0] got;
    exp_free[0] = 4'b0001;
    exp_free[1] = 4'b0011;
    exp_free[2] = 4'b1011;
    do_reset();
    for (int k = 0; k < 4; k++) dispatch(32'(10 + k));
    core_done   = 4'b1011;
    core_digest = {128'h3, 128'h2, 128'h1, 128'h5};
    step();
    core_done = '0;
    checks++;
    if (cand_ready !== 1'b0) begin
      errors++;
      $display("FAIL nm_ready: got %b want 0", cand_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      got = '0;
      for (int i = 0; i < 4; i++) got[i] = dut.state[i] == SLOT_FREE;
      checks++;
      if (got !== exp_free[c] || match_valid !== 1'b0) begin
        errors++;
        $display("FAIL nm_order%0d: got free=%b mv=%b want %b/0",
                 c, got, match_valid, exp_free[c]);
      end
    end
    step();
    checks++;
    if (match_valid !== 1'b0) begin
      errors++;
      $display("FAIL nm_late_match: got %b want 0", match_valid);
    end
`ifdef MD4_SCHED_STATS_EN
    checks++;
    if (stat_done_cnt !== 32'd3) begin
      errors++;
      $display("FAIL nm_done_cnt: got %0d want 3", stat_done_cnt);
    end
`endif
  endtask

  task automatic test_spurious();
    do_reset();
    core_done = 4'b0010;
    step();
    core_done = '0;
    step();
    checks++;
    if (dut.state[1] !== SLOT_FREE || idle !== 1'b1 || match_valid !== 1'b0) begin
      errors++;
      $display("FAIL spur_state: got st=%0d idle=%b mv=%b want FREE/1/0",
               dut.state[1], idle, match_valid);
    end
`ifdef MD4_SCHED_STATS_EN
    checks++;
    if (stat_err_cnt !== 16'd1 || stat_done_cnt !== 32'd0) begin
      errors++;
      $display("FAIL spur_cnt: got err=%0d done=%0d want 1/0",
               stat_err_cnt, stat_done_cnt);
    end
`endif
  endtask

  task automatic test_enable();
    do_reset();
    dispatch(32'd20);
    dispatch(32'd21);
    enable     = 1'b0;
    cand_valid = 1'b1;
    cand_idx   = 32'd22;
    #1;
    checks++;
    if (cand_ready !== 1'b0) begin
      errors++;
      $display("FAIL en_ready: got %b want 0", cand_ready);
    end
    step();
    step();
    checks++;
    if (core_start !== 4'b0000) begin
      errors++;
      $display("FAIL en_start: got %b want 0000", core_start);
    end
    core_done   = 4'b0011;
    core_digest = {128'h0, 128'h0, 128'hA, 128'hB};
    step();
    core_done = '0;
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL en_busy: got %b want 0", idle);
    end
    step();
    step();
    checks++;
    if (idle !== 1'b1 || core_start !== 4'b0000) begin
      errors++;
      $display("FAIL en_idle: got idle=%b st=%b want 1/0000", idle, core_start);
    end
    cand_valid = 1'b0;
    enable     = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    dispatch(32'd30);
    dispatch(32'd31);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (core_start !== 4'b0000 || idle !== 1'b1 || match_idx !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: got st=%b idle=%b mi=%0d want 0000/1/0",
               core_start, idle, match_idx);
    end
    reset       = 1'b0;
    core_done   = 4'b0011;
    core_digest = '0;
    step();
    core_done = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (match_valid !== 1'b0 || idle !== 1'b1) begin
        errors++;
        $display("FAIL rst_ignore%0d: got mv=%b idle=%b want 0/1",
                 c, match_valid, idle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_match();
    test_no_match();
    test_spurious();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
